// File: rtl/formula_nested_sqrt_pipe.sv
`default_nettype none
// ============================================================================
// Module      : formula_nested_sqrt_pipe
// Description : Pipelined nested integer square root,
//               res = isqrt(t[N-1] + isqrt(t[N-2] + ... + isqrt(t[0]))),
//               with saturating sums and a stall-on-backpressure handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module formula_nested_sqrt_pipe #(
    parameter int W       = 32,
    parameter int N_TERMS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arg_vld,
    output logic                 arg_rdy,
    input  logic [N_TERMS*W-1:0] args,
    output logic                 res_vld,
    input  logic                 res_rdy,
    output logic [W/2-1:0]       res
);

    localparam int c_half = W / 2;
    localparam int c_remw = c_half + 2;

    typedef struct packed {
        logic [c_remw-1:0] rem;
        logic [c_half-1:0] root;
        logic [W-1:0]      x;
    } step_t;

    // One restoring digit step: bring down the next two operand bits and
    // try to subtract (4*root + 1) from the running remainder.
    function automatic step_t sqrt_step(input step_t s);
        step_t             o;
        logic [c_remw-1:0] w_rem;
        logic [c_remw-1:0] w_trial;
        w_rem   = (s.rem << 2) | c_remw'(s.x[W-1 -: 2]);
        w_trial = {s.root, 2'b01};
        o.x     = s.x << 2;
        if (w_rem >= w_trial) begin
            o.rem  = w_rem - w_trial;
            o.root = (s.root << 1) | c_half'(1);
        end else begin
            o.rem  = w_rem;
            o.root = s.root << 1;
        end
        return o;
    endfunction

    logic              w_adv;
    logic [c_half-1:0] w_root     [N_TERMS];
    logic              w_root_vld [N_TERMS];

    assign w_adv   = !res_vld || res_rdy;
    assign arg_rdy = w_adv;

    generate
        for (genvar k = 0; k < N_TERMS; k++) begin : g_term
            step_t             w_op;
            logic              w_op_vld;
            step_t             r_stage [c_half];
            logic [c_half-1:0] r_vld;

            if (k == 0) begin : g_direct
                assign w_op     = {c_remw'(0), c_half'(0), args[0 +: W]};
                assign w_op_vld = arg_vld && w_adv;
            end else begin : g_sum
                // Delay t[k] until the previous unit's root for the same item emerges.
                localparam int c_depth = k * (c_half + 1) - 1;

                logic [W-1:0] r_dly [c_depth];
                logic [W:0]   w_sum;
                logic [W-1:0] r_sum;
                logic         r_sum_vld;

                assign w_sum = {1'b0, r_dly[c_depth-1]} + (W+1)'(w_root[k-1]);

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int i = 0; i < c_depth; i++) begin
                            r_dly[i] <= '0;
                        end
                        r_sum     <= '0;
                        r_sum_vld <= 1'b0;
                    end else if (w_adv) begin
                        r_dly[0] <= args[k*W +: W];
                        for (int i = 1; i < c_depth; i++) begin
                            r_dly[i] <= r_dly[i-1];
                        end
                        r_sum     <= w_sum[W] ? '1 : w_sum[W-1:0];
                        r_sum_vld <= w_root_vld[k-1];
                    end
                end

                assign w_op     = {c_remw'(0), c_half'(0), r_sum};
                assign w_op_vld = r_sum_vld;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < c_half; i++) begin
                        r_stage[i] <= '0;
                    end
                    r_vld <= '0;
                end else if (w_adv) begin
                    r_stage[0] <= sqrt_step(w_op);
                    r_vld[0]   <= w_op_vld;
                    for (int i = 1; i < c_half; i++) begin
                        r_stage[i] <= sqrt_step(r_stage[i-1]);
                        r_vld[i]   <= r_vld[i-1];
                    end
                end
            end

            assign w_root[k]     = r_stage[c_half-1].root;
            assign w_root_vld[k] = r_vld[c_half-1];
        end
    endgenerate

    assign res     = w_root[N_TERMS-1];
    assign res_vld = w_root_vld[N_TERMS-1];

endmodule
`default_nettype wire

// File: tb/tb_formula_nested_sqrt_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_formula_nested_sqrt_pipe
// Description : Scoreboard bench for the nested square-root pipeline,
//               W=32/N=3 and W=8/N=1 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_formula_nested_sqrt_pipe;

    logic        clk;
    logic        rst;

    logic        arg_vld_a, arg_rdy_a, res_vld_a, res_rdy_a;
    logic [95:0] args_a;
    logic [15:0] res_a;

    logic        arg_vld_b, arg_rdy_b, res_vld_b, res_rdy_b;
    logic [7:0]  args_b;
    logic [3:0]  res_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] v;
        int          c;
    } ent_t;

    ent_t sba[$];
    ent_t sbb[$];

    bit          lat_chk    = 1'b1;
    bit          bp         = 1'b0;
    int          n_out_a    = 0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_res   = '0;

    formula_nested_sqrt_pipe #(.W(32), .N_TERMS(3)) u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .arg_vld (arg_vld_a),
        .arg_rdy (arg_rdy_a),
        .args    (args_a),
        .res_vld (res_vld_a),
        .res_rdy (res_rdy_a),
        .res     (res_a)
    );

    formula_nested_sqrt_pipe #(.W(8), .N_TERMS(1)) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .arg_vld (arg_vld_b),
        .arg_rdy (arg_rdy_b),
        .args    (args_b),
        .res_vld (res_vld_b),
        .res_rdy (res_rdy_b),
        .res     (res_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Largest r with r*r <= x, built up by trial squaring.
    function automatic longint unsigned isq(input longint unsigned x);
        longint unsigned r;
        longint unsigned t;
        r = 0;
        for (int b = 20; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= x) r = t;
        end
        return r;
    endfunction

    function automatic logic [15:0] model_a(input logic [95:0] a);
        longint unsigned r;
        longint unsigned s;
        r = isq(64'(a[31:0]));
        for (int k = 1; k < 3; k++) begin
            s = 64'(a[k*32 +: 32]) + r;
            if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
            r = isq(s);
        end
        return r[15:0];
    endfunction

    function automatic logic [95:0] rand_args();
        logic [95:0] a;
        a = {$urandom, $urandom, $urandom};
        if ($urandom_range(0, 3) == 0) a[63:32] = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) a[95:64] = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
        return a;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send_a(input logic [95:0] a, input logic [15:0] e);
        int g;
        g         = 0;
        args_a    = a;
        arg_vld_a = 1'b1;
        #1;
        while (!arg_rdy_a && g < 5000) begin
            @(posedge clk);
            #2;
            g++;
        end
        if (arg_rdy_a) sba.push_back('{v: e, c: cyc});
        else chk("send_a_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        arg_vld_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] a, input logic [3:0] e);
        int g;
        g         = 0;
        args_b    = a;
        arg_vld_b = 1'b1;
        #1;
        while (!arg_rdy_b && g < 100) begin
            @(posedge clk);
            #2;
            g++;
        end
        if (arg_rdy_b) sbb.push_back('{v: 16'(e), c: cyc});
        else chk("send_b_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        arg_vld_b = 1'b0;
    endtask

    task automatic drain_a(input int budget);
        int i;
        i = 0;
        while (sba.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        @(posedge clk);
        #1;
        chk("drain_a", 64'(sba.size()), 64'd0);
    endtask

    task automatic drain_b(input int budget);
        int i;
        i = 0;
        while (sbb.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        @(posedge clk);
        #1;
        chk("drain_b", 64'(sbb.size()), 64'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp) res_rdy_a = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard pop, handshake and stall-stability checks for the wide instance.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            chk("arg_rdy_a", 64'(arg_rdy_a), 64'(!res_vld_a || res_rdy_a));
            if (prev_stall) begin
                chk("stall_vld", 64'(res_vld_a), 64'd1);
                chk("stall_res", 64'(res_a), 64'(prev_res));
            end
            if (res_vld_a && res_rdy_a) begin
                if (sba.size() == 0) begin
                    chk("spurious_a", 64'd0, 64'd1);
                end else begin
                    ent_t e;
                    e = sba.pop_front();
                    chk("res_a", 64'(res_a), 64'(e.v));
                    if (lat_chk) chk("lat_a", 64'(cyc - e.c), 64'd50);
                    n_out_a++;
                end
            end
            prev_stall = res_vld_a && !res_rdy_a;
            prev_res   = res_a;
        end
    end

    always @(negedge clk) begin
        if (!rst && res_vld_b) begin
            if (sbb.size() == 0) begin
                chk("spurious_b", 64'd0, 64'd1);
            end else begin
                ent_t e;
                e = sbb.pop_front();
                chk("res_b", 64'(res_b), 64'(e.v));
                chk("lat_b", 64'(cyc - e.c), 64'd4);
            end
        end
    end

    initial begin
        int          base;
        bit          seen;
        logic [95:0] a;

        rst       = 1'b1;
        arg_vld_a = 1'b0;
        args_a    = '0;
        res_rdy_a = 1'b1;
        arg_vld_b = 1'b0;
        args_b    = '0;
        res_rdy_b = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_vld_a", 64'(res_vld_a), 64'd0);
        chk("rst_res_a", 64'(res_a), 64'd0);
        chk("rst_arg_rdy_a", 64'(arg_rdy_a), 64'd1);
        chk("rst_res_vld_b", 64'(res_vld_b), 64'd0);
        chk("rst_res_b", 64'(res_b), 64'd0);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_arg_rdy_a", 64'(arg_rdy_a), 64'd1);

        // Directed values, including saturation of the middle sum.
        send_a({32'd7, 32'd5, 32'd16}, 16'd3);
        drain_a(200);
        send_a(96'd0, 16'd0);
        drain_a(200);
        send_a({32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 16'd256);
        send_a({32'd0, 32'hFFFF_FFFF, 32'd0}, 16'd255);
        drain_a(200);

        // Back-to-back stream.
        base = n_out_a;
        for (int i = 0; i < 200; i++) begin
            a = rand_args();
            send_a(a, model_a(a));
        end
        drain_a(300);
        chk("stream_count", 64'(n_out_a - base), 64'd200);

        // Random backpressure and random source gaps.
        lat_chk = 1'b0;
        bp      = 1'b1;
        base    = n_out_a;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk);
                #1;
            end
            a = rand_args();
            send_a(a, model_a(a));
        end
        drain_a(6000);
        chk("bp_count", 64'(n_out_a - base), 64'd1000);
        bp = 1'b0;
        @(posedge clk);
        #1;
        res_rdy_a = 1'b1;
        lat_chk   = 1'b1;

        // Asynchronous reset with items in flight.
        for (int i = 0; i < 20; i++) begin
            a = rand_args();
            send_a(a, model_a(a));
        end
        #3;
        rst = 1'b1;
        sba.delete();
        #1;
        chk("midrst_res_vld", 64'(res_vld_a), 64'd0);
        chk("midrst_res", 64'(res_a), 64'd0);
        repeat (2) @(posedge clk);
        #4;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (res_vld_a) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("post_rst_quiet", 64'(seen), 64'd0);
        a = rand_args();
        send_a(a, model_a(a));
        drain_a(200);

        // Narrow single-term instance: directed then exhaustive.
        send_b(8'd200, 4'd14);
        send_b(8'd255, 4'd15);
        send_b(8'd0, 4'd0);
        for (int x = 0; x < 256; x++) begin
            send_b(8'(x), 4'(isq(64'(x))));
        end
        drain_b(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/formula_nested_sqrt_pipe.md
# formula_nested_sqrt_pipe

Fully pipelined evaluator of the nested square-root formula res = isqrt(t[N-1] + isqrt(t[N-2] + … + isqrt(t[0]))), with a configurable operand width and number of terms. It carries its own bit-serial-per-stage integer square-root pipeline, so it does not depend on an external isqrt instance. It adds saturating intermediate sums and a valid/ready output handshake with global pipeline stall. It sits in the arithmetic datapath as the generalised replacement for the fixed three-term, 32-bit formula pipelines.

## Interface
- W, default 32: operand width; must be even and at least 4. Each isqrt result is W/2 bits.
- N_TERMS, default 3: number of nested terms; at least 1.
- clk  input  1  clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- arg_vld  input  1  the operand vector on args is valid this cycle.
- arg_rdy  output  1  the block accepts args this cycle; a transfer happens when arg_vld && arg_rdy.
- args  input  N_TERMS*W  packed terms; t[k] = args[k*W +: W]. t[0] is the innermost term, t[N_TERMS-1] the outermost.
- res_vld  output  1  res holds a valid result.
- res_rdy  input  1  downstream consumes the result; a transfer happens when res_vld && res_rdy.
- res  output  W/2  final isqrt result.

## Operation
- Each isqrt unit is a restoring digit-by-digit square root of a W-bit operand.
  - It has W/2 register stages and resolves one result bit per stage, MSB first.
  - Each stage carries a remainder, a partial root and a valid bit.
  - The output is floor(sqrt(x)), exact for all x in 0..2^W-1.
- Term k ≥ 1 path:
  - Sum s[k] = t[k] + zero-extended isqrt result of term k-1, computed at W+1 bits.
  - If bit W of the sum is set, the sum saturates to 2^W-1.
  - s[k] is registered in one adder stage before entering isqrt unit k.
- Term 0 feeds isqrt unit 0 directly, with no adder stage.
- Term delay lines:
  - t[k] is delayed in a W-bit shift register of depth k*(W/2) + (k-1) + 1 - 1 = k*(W/2+1) - 1 cycles.
  - This aligns t[k] with the output of isqrt unit k-1.
  - Delay lines advance only on the global enable.
- Global advance enable: adv = !res_vld || res_rdy.
  - When adv=0, every pipeline register, valid bit and delay line holds its value.
  - When adv=1, all of them shift by one stage.
- arg_rdy = adv, combinational from res_vld and res_rdy.
- A stage's valid bit is loaded from the previous stage's valid bit when adv=1. The stage-0 valid is loaded from arg_vld && arg_rdy.
  - Data registers of invalid stages may change; they are don't-care.
- res and res_vld are driven directly by the last stage of isqrt unit N_TERMS-1.
- Reset values:
  - All valid bits are 0, so res_vld=0.
  - res=0, and all data and delay registers are 0.
  - arg_rdy=1 while reset is deasserted and the pipeline is empty.
- Reset mid-operation: all in-flight results are discarded immediately and asynchronously. No valid result appears after reset release unless new args are accepted.

## Timing
- Latency from accept to res_vld is L = N_TERMS*(W/2) + (N_TERMS-1) cycles, with no stalls.
  - W=32, N_TERMS=3: L = 50.
  - W=8, N_TERMS=1: L = 4.
- Each cycle with adv=0 adds exactly one cycle to the latency of every in-flight item.
- Throughput is one result per cycle while res_rdy=1; back-to-back accepts are allowed. At most L items are in flight.
- Bubbles: when res_vld=0, the pipeline advances regardless of res_rdy, so internal bubbles collapse toward the output.
- While res_vld && !res_rdy, res and res_vld are held stable and arg_rdy=0.
- When arg_vld=1 and arg_rdy=0, nothing is captured; the source must hold args stable.
- Reset is applied asynchronously; its release is synchronised to clk by the surrounding design.

## Test plan
- Basic, W=32, N=3, res_rdy=1: c=16, b=5, a=7 (t0=16, t1=5, t2=7).
  - isqrt(16)=4; 5+4=9 gives 3; 7+3=10 gives 3.
  - Required: res=3 with res_vld exactly 50 cycles after accept. Also all-zero args give res=0.
- Saturation: t0=t1=0xFFFFFFFF, t2=1.
  - 65535, then the saturated sum gives 65535, then 1+65535=65536 gives res=256.
  - Also t0=0, t1=0xFFFFFFFF, t2=0: 0xFFFFFFFF gives 65535, then 0+65535 gives res=255.
- Streaming: 200 back-to-back random accepts, checked against a reference model.
  - Required: 200 results in order, one per cycle, with no gaps after the first one at cycle 50.
- Backpressure: random res_rdy (50%) and random arg_vld over 1000 items.
  - Required: no loss, no duplication, order preserved.
  - res stays stable while stalled; arg_rdy = !res_vld || res_rdy every cycle.
- Reset mid-stream: assert rst asynchronously with 20 items in flight, between clock edges.
  - Required: res_vld=0 and res=0 immediately.
  - After release, no result appears until a new accept; the first new result arrives 50 cycles after that accept.
- Parameter corner, W=8, N_TERMS=1:
  - t0=200 gives res=14 after 4 cycles; t0=255 gives 15; t0=0 gives 0.
  - Exhaustive sweep of t0 in 0..255 matches floor(sqrt).
